// File: rtl/uart_rx_unit_pkg.sv
// Shared definitions for the UART receive path: FSM state encodings,
// default line-rate constants, frame bit levels and the tick divisor helper.
package uart_rx_unit_pkg;

  // Receiver FSM states (3-bit encoding shared with the transmitter side)
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_e;

  localparam int DEFAULT_CLK_FREQ   = 50_000_000;
  localparam int DEFAULT_BAUD       = 115_200;
  localparam int DEFAULT_OVERSAMPLE = 16;

  // Line levels of the framing bits
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Clock cycles per oversample tick (integer division, truncating)
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Free-running oversample tick divider: tick is high for one clk every DIV
// clocks, in the cycle where the internal counter sits at DIV-1.
module uart_rx_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("uart_rx_tick: DIV must be >= 2");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next counter value with wrap at DIV-1; tick is precomputed so it is a flop
  always_comb begin
    if (cnt_q == LAST) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    tick_d = (cnt_d == LAST);
  end

  // Counter and registered tick
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= {CW{1'b0}};
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_rx_unit.sv
// UART receiver: 2-flop synchronizer, oversampled start-bit validation,
// mid-bit sampling of WIDTH data bits (LSB first), stop-bit check and a
// level data_valid / ack handshake with overrun and framing-error pulses.
module uart_rx_unit
  import uart_rx_unit_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int BAUD       = DEFAULT_BAUD,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  input  logic             ack,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy,
  output logic [3:0]       bit_counter
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam logic [SCW-1:0] MID_START   = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] LAST_SAMPLE = SCW'(OVERSAMPLE - 1);
  localparam logic [3:0]     LAST_BIT    = 4'(WIDTH - 1);

  if (WIDTH < 1 || WIDTH > 15) begin : g_width_check
    $error("uart_rx_unit: WIDTH must be in 1..15");
  end
  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_os_check
    $error("uart_rx_unit: OVERSAMPLE must be even and >= 4");
  end
  if (DIV < 2) begin : g_div_check
    $error("uart_rx_unit: CLK_FREQ/(BAUD*OVERSAMPLE) must be >= 2");
  end

  logic tick;

  uart_rx_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Synchronizer flops; idle-high so a reset never looks like a start bit
  logic rx_meta_q, rx_s_q;

  // Two-flop synchronizer for the asynchronous rx pin
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  rx_state_e        state_q, state_d;
  logic [SCW-1:0]   sample_cnt_q, sample_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             data_valid_q, data_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;

  // Next-state logic: FSM moves on ticks, handshake and pulses every clk
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    data_d       = data_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;

    // ack only matters while a word is pending
    if (ack && data_valid_q) begin
      data_valid_d = 1'b0;
    end else begin
      data_valid_d = data_valid_q;
    end

    if (tick) begin
      case (state_q)
        IDLE: begin
          if (rx_s_q == START_BIT) begin
            state_d      = START;
            sample_cnt_d = {SCW{1'b0}};
          end else begin
            state_d = IDLE;
          end
        end
        START: begin
          if (sample_cnt_q == MID_START) begin
            if (rx_s_q == START_BIT) begin
              state_d      = DATA;
              sample_cnt_d = {SCW{1'b0}};
              bit_cnt_d    = 4'd0;
            end else begin
              // Start bit gone by mid-bit: a glitch, drop it silently
              state_d = IDLE;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + SCW'(1);
          end
        end
        DATA: begin
          if (sample_cnt_q == LAST_SAMPLE) begin
            shift_d            = shift_q >> 1;
            shift_d[WIDTH-1]   = rx_s_q;
            bit_cnt_d          = bit_cnt_q + 4'd1;
            sample_cnt_d       = {SCW{1'b0}};
            if (bit_cnt_q == LAST_BIT) begin
              state_d = STOP;
            end else begin
              state_d = DATA;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + SCW'(1);
          end
        end
        STOP: begin
          if (sample_cnt_q == LAST_SAMPLE) begin
            if (rx_s_q == STOP_BIT) begin
              data_d       = shift_q;
              // Overrides an ack clear: a same-cycle ack consumes the old word
              data_valid_d = 1'b1;
              overrun_d    = data_valid_q & ~ack;
              state_d      = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = WAIT_HIGH;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + SCW'(1);
          end
        end
        WAIT_HIGH: begin
          // Hold through a break / stuck-low line until it returns high
          if (rx_s_q == STOP_BIT) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT_HIGH;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    busy_d = (state_d != IDLE);
  end

  // FSM, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sample_cnt_q <= {SCW{1'b0}};
      shift_q      <= {WIDTH{1'b0}};
      bit_cnt_q    <= 4'd0;
      data_q       <= {WIDTH{1'b0}};
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign data        = data_q;
  assign data_valid  = data_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;
  assign busy        = busy_q;
  assign bit_counter = bit_cnt_q;

endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed bench for uart_rx_unit: 160 clk per bit (DIV=10, OVERSAMPLE=16).
module tb_uart_rx_unit;

  localparam int WIDTH      = 8;
  localparam int CLK_FREQ   = 1_600_000;
  localparam int BAUD       = 10_000;
  localparam int OVERSAMPLE = 16;
  localparam int BIT_CLK    = 160;
  localparam int PERIOD     = 10;

  logic             clk;
  logic             reset;
  logic             rx;
  logic             ack;
  logic [WIDTH-1:0] data;
  logic             data_valid;
  logic             frame_err;
  logic             overrun;
  logic             busy;
  logic [3:0]       bit_counter;

  int tests_run    = 0;
  int tests_failed = 0;

  // Event monitor state (written only by the monitor process)
  int   fe_cnt      = 0;
  int   ov_cnt      = 0;
  int   dv_rise_cnt = 0;
  int   dv_fall_cnt = 0;
  int   busy_cyc    = 0;
  time  dv_rise_t   = 0;
  time  busy_fall_t = 0;
  logic dv_prev     = 1'b0;
  logic busy_prev   = 1'b0;

  uart_rx_unit #(
    .WIDTH      (WIDTH),
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .ack         (ack),
    .data        (data),
    .data_valid  (data_valid),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .busy        (busy),
    .bit_counter (bit_counter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count pulses and edges of the outputs, sampled mid-cycle
  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (data_valid === 1'b1 && dv_prev === 1'b0) begin
      dv_rise_cnt++;
      dv_rise_t = $time;
    end
    if (data_valid === 1'b0 && dv_prev === 1'b1) dv_fall_cnt++;
    if (busy === 1'b1) busy_cyc++;
    if (busy === 1'b0 && busy_prev === 1'b1) busy_fall_t = $time;
    dv_prev   = data_valid;
    busy_prev = busy;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Full frame; rx is left at the stop-bit level afterwards
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clk(BIT_CLK);
    end
    rx = stop_bit;
    wait_clk(BIT_CLK);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    wait_clk(1);
    ack = 1'b0;
    wait_clk(1);
  endtask

  initial begin
    time    t0;
    time    t1;
    longint lat;
    longint c0;
    longint need;
    longint d1;
    longint comp1;
    int     fe0;
    int     ov0;
    int     r0;
    int     f0;
    int     b0;
    int     bc;
    logic   aligned;

    reset = 1'b1;
    rx    = 1'b1;
    ack   = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_data_valid", 32'(data_valid), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bit_counter", 32'(bit_counter), 32'd0);
    reset = 1'b0;
    wait_clk(50);

    // 1: 0xA5 with latency window and busy/data_valid alignment
    fe0 = fe_cnt;
    r0  = dv_rise_cnt;
    t0  = $time;
    send_frame(8'hA5, 1'b1);
    lat = longint'(dv_rise_t - t0) / PERIOD;
    chk("t1_data", 32'(data), 32'hA5);
    chk("t1_data_valid", 32'(data_valid), 32'd1);
    chk("t1_bit_counter", 32'(bit_counter), 32'd8);
    chk("t1_frame_err_cnt", 32'(fe_cnt - fe0), 32'd0);
    chk("t1_dv_rises", 32'(dv_rise_cnt - r0), 32'd1);
    chk("t1_latency_1507_1533", 32'(lat >= 1507 && lat <= 1533), 32'd1);
    chk("t1_busy_fall_same_cycle", 32'(busy_fall_t == dv_rise_t), 32'd1);
    chk("t1_busy_after", 32'(busy), 32'd0);
    pulse_ack();
    chk("t1_ack_clears", 32'(data_valid), 32'd0);

    // 2: ack clears; second word without ack overruns
    ov0 = ov_cnt;
    send_frame(8'h3C, 1'b1);
    chk("t2_data_3c", 32'(data), 32'h3C);
    pulse_ack();
    chk("t2_ack_clears", 32'(data_valid), 32'd0);
    send_frame(8'hFF, 1'b1);
    chk("t2_data_ff", 32'(data), 32'hFF);
    chk("t2_dv_ff", 32'(data_valid), 32'd1);
    chk("t2_no_overrun_ff", 32'(ov_cnt - ov0), 32'd0);
    send_frame(8'h00, 1'b1);
    chk("t2_data_00", 32'(data), 32'h00);
    chk("t2_dv_00", 32'(data_valid), 32'd1);
    chk("t2_overrun_1cyc", 32'(ov_cnt - ov0), 32'd1);
    pulse_ack();
    chk("t2_idle_ack_ignored_pre", 32'(data_valid), 32'd0);
    pulse_ack();
    chk("t2_idle_ack_ignored", 32'(data_valid), 32'd0);

    // 3: 40-clk glitch: 8 ticks of busy, nothing delivered
    b0 = busy_cyc;
    r0 = dv_rise_cnt;
    rx = 1'b0;
    wait_clk(40);
    rx = 1'b1;
    wait_clk(300);
    bc = busy_cyc - b0;
    chk("t3_busy_70_90", 32'(bc >= 70 && bc <= 90), 32'd1);
    chk("t3_busy_after", 32'(busy), 32'd0);
    chk("t3_no_word", 32'(dv_rise_cnt - r0), 32'd0);
    chk("t3_dv", 32'(data_valid), 32'd0);

    // 4: framing error, line break, recovery
    fe0 = fe_cnt;
    r0  = dv_rise_cnt;
    send_frame(8'h55, 1'b0);
    wait_clk(5 * BIT_CLK);
    chk("t4_busy_in_break", 32'(busy), 32'd1);
    chk("t4_frame_err_once", 32'(fe_cnt - fe0), 32'd1);
    chk("t4_data_kept", 32'(data), 32'h00);
    chk("t4_no_word", 32'(dv_rise_cnt - r0), 32'd0);
    rx = 1'b1;
    wait_clk(30);
    chk("t4_busy_after_high", 32'(busy), 32'd0);
    wait_clk(170);
    send_frame(8'h81, 1'b1);
    chk("t4_data_81", 32'(data), 32'h81);
    chk("t4_dv_81", 32'(data_valid), 32'd1);
    chk("t4_frame_err_total", 32'(fe_cnt - fe0), 32'd1);

    // 5: reset in data bit 4 of 0xC3; the sender is reset too, so the line idles
    r0 = dv_rise_cnt;
    rx = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      rx = (i < 2) ? 1'b1 : 1'b0;
      wait_clk(BIT_CLK);
    end
    rx = 1'b0;
    wait_clk(60);
    chk("t5_bits_before_reset", 32'(bit_counter), 32'd4);
    chk("t5_busy_before_reset", 32'(busy), 32'd1);
    reset = 1'b1;
    rx    = 1'b1;
    wait_clk(1);
    reset = 1'b0;
    chk("t5_rst_data", 32'(data), 32'h00);
    chk("t5_rst_dv", 32'(data_valid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_bit_counter", 32'(bit_counter), 32'd0);
    chk("t5_rst_pulses", 32'({frame_err, overrun}), 32'd0);
    wait_clk(300);
    send_frame(8'h12, 1'b1);
    chk("t5_data_12", 32'(data), 32'h12);
    chk("t5_only_one_word", 32'(dv_rise_cnt - r0), 32'd1);
    pulse_ack();

    // 6: back-to-back 0x0F, 0xF0 with ack on the 0xF0 completion cycle
    r0 = dv_rise_cnt;
    send_frame(8'h0F, 1'b1);
    chk("t6_data_0f", 32'(data), 32'h0F);
    chk("t6_dv_0f", 32'(dv_rise_cnt - r0), 32'd1);
    // Completion edge of 0x0F fixes the tick grid (10 clk per tick);
    // 0xF0 start is seen on the first grid edge >= 2.5 clk after rx falls
    c0    = longint'(dv_rise_t) - 5;
    t1    = $time;
    need  = longint'(t1) + 25 - c0;
    d1    = c0 + 100 * ((need + 99) / 100);
    comp1 = d1 + 15200;
    f0    = dv_fall_cnt;
    ov0   = ov_cnt;
    aligned = 1'b0;
    fork
      send_frame(8'hF0, 1'b1);
      begin
        for (int n = 0; n < 3000; n++) begin
          if (longint'($time) >= comp1 - 5) break;
          @(negedge clk);
        end
        aligned = (longint'($time) == comp1 - 5);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
      end
    join
    chk("t6_ack_window_hit", 32'(aligned), 32'd1);
    chk("t6_data_f0", 32'(data), 32'hF0);
    chk("t6_dv_stays", 32'(data_valid), 32'd1);
    chk("t6_dv_never_fell", 32'(dv_fall_cnt - f0), 32'd0);
    chk("t6_no_overrun", 32'(ov_cnt - ov0), 32'd0);
    pulse_ack();
    chk("t6_final_ack", 32'(data_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
